mult_div_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 18 +
 rtl/mult_div_unit_abs.sv | 12 +
 rtl/mult_div_unit.sv | 119 +++++++++++
 tb/tb_mult_div_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the multicycle multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit_abs.sv
// Two's-complement conditional negate: magnitude of a signed operand, or sign fix-up of a result.
module mdu_abs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result_c
);

  assign result_c = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle shift-add multiplier / restoring divider with HI/LO result registers.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_load,
  input  logic             lo_load,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t state, state_n;
  mdu_op_t    op_in;

  logic [2*WIDTH-1:0] acc, acc_step, acc_fix;
  logic [WIDTH-1:0]   opnd, abs_a, abs_b, rem_fix;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_q, neg_r;
  logic               is_div_in, signed_in, start_dz;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;

  assign op_in     = mdu_op_t'(op);
  assign is_div_in = (op_in == MDU_DIV) || (op_in == MDU_DIVU);
  assign signed_in = (op_in == MDU_MULT) || (op_in == MDU_DIV);
  assign start_dz  = is_div_in && (b == '0);

  // Operand magnitudes on the way in, sign fix-up of the accumulator on the way out.
  mdu_abs #(.WIDTH(WIDTH)) u_abs_a (.value(a), .neg(signed_in & a[WIDTH-1]), .result_c(abs_a));
  mdu_abs #(.WIDTH(WIDTH)) u_abs_b (.value(b), .neg(signed_in & b[WIDTH-1]), .result_c(abs_b));
  mdu_abs #(.WIDTH(2*WIDTH)) u_fix_acc (.value(acc), .neg(neg_q), .result_c(acc_fix));
  mdu_abs #(.WIDTH(WIDTH)) u_fix_rem (.value(acc[2*WIDTH-1:WIDTH]), .neg(neg_r), .result_c(rem_fix));

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd};
    if (is_div) begin
      if (div_diff[WIDTH]) acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else                 acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = start_dz ? DONE : RUN;
      RUN:     if (cnt == '0) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      state    <= state_n;
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
      div_zero <= (state == IDLE) && start && start_dz;
      case (state)
        IDLE: begin
          if (hi_load) hi <= a;
          if (lo_load) lo <= a;
          if (start) begin
            is_div <= is_div_in;
            neg_q  <= signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= signed_in & a[WIDTH-1];
            acc    <= {{WIDTH{1'b0}}, abs_a};
            opnd   <= abs_b;
            cnt    <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
        end
        // Results land at the end of FIX so they are visible throughout DONE.
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= acc_fix[WIDTH-1:0];
          end else begin
            hi <= acc_fix[2*WIDTH-1:WIDTH];
            lo <= acc_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset, start, hi_load, lo_load;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_load(hi_load), .lo_load(lo_load), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one op and wait for done; cyc is the cycle done was seen (start cycle = 0).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int cyc, output logic [31:0] r_hi, output logic [31:0] r_lo,
                        output logic r_dz, output logic r_busy, output logic post_busy);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; a = 32'hA5A5_5A5A; b = 32'h0; op = 2'b01;
    cyc = 1;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    r_hi = hi; r_lo = lo; r_dz = div_zero; r_busy = busy;
    tick();
    post_busy = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin bad++;
      $display("FAIL reset_flags: got busy=%b done=%b dz=%b want 0 0 0", busy, done, div_zero); end
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++;
      $display("FAIL reset_hilo: got %h %h want 0 0", hi, lo); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    int c; logic [31:0] rh, rl; logic dz, bz, pb;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, c, rh, rl, dz, bz, pb);
    total++; if (c !== 34) begin bad++; $display("FAIL mult_latency: got %0d want 34", c); end
    total++; if (rh !== 32'hFFFF_FFFF || rl !== 32'hFFFF_FFEB) begin bad++;
      $display("FAIL mult_neg: got %h_%h want ffffffff_ffffffeb", rh, rl); end
    total++; if (bz !== 1'b1 || pb !== 1'b0) begin bad++;
      $display("FAIL mult_busy: got during=%b after=%b want 1 0", bz, pb); end
    run_op(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, c, rh, rl, dz, bz, pb);
    total++; if (rh !== 32'h0 || rl !== 32'd30) begin bad++;
      $display("FAIL mult_negneg: got %h_%h want 00000000_0000001e", rh, rl); end
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, rh, rl, dz, bz, pb);
    total++; if (rh !== 32'hFFFF_FFFE || rl !== 32'h0000_0001) begin bad++;
      $display("FAIL multu_max: got %h_%h want fffffffe_00000001", rh, rl); end
  endtask

  task automatic test_div();
    int c; logic [31:0] rh, rl; logic dz, bz, pb;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, c, rh, rl, dz, bz, pb);
    total++; if (c !== 34 || dz !== 1'b0) begin bad++;
      $display("FAIL div_latency: got cyc=%0d dz=%b want 34 0", c, dz); end
    total++; if (rl !== 32'hFFFF_FFFD || rh !== 32'hFFFF_FFFF) begin bad++;
      $display("FAIL div_neg: got q=%h r=%h want fffffffd ffffffff", rl, rh); end
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, c, rh, rl, dz, bz, pb);
    total++; if (rl !== 32'hFFFF_FFFD || rh !== 32'd1) begin bad++;
      $display("FAIL div_negdivisor: got q=%h r=%h want fffffffd 00000001", rl, rh); end
    run_op(2'b11, 32'd7, 32'd2, c, rh, rl, dz, bz, pb);
    total++; if (rl !== 32'd3 || rh !== 32'd1) begin bad++;
      $display("FAIL divu_small: got q=%h r=%h want 00000003 00000001", rl, rh); end
    run_op(2'b11, 32'hFFFF_FFFF, 32'h0001_0000, c, rh, rl, dz, bz, pb);
    total++; if (rl !== 32'h0000_FFFF || rh !== 32'h0000_FFFF) begin bad++;
      $display("FAIL divu_large: got q=%h r=%h want 0000ffff 0000ffff", rl, rh); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, c, rh, rl, dz, bz, pb);
    total++; if (rl !== 32'h8000_0000 || rh !== 32'h0 || dz !== 1'b0) begin bad++;
      $display("FAIL div_overflow: got q=%h r=%h dz=%b want 80000000 00000000 0", rl, rh, dz); end
  endtask

  task automatic test_div_zero();
    int c; logic [31:0] rh, rl; logic dz, bz, pb;
    a = 32'h1234; hi_load = 1'b1; tick(); hi_load = 1'b0;
    a = 32'h5678; lo_load = 1'b1; tick(); lo_load = 1'b0;
    total++; if (hi !== 32'h1234 || lo !== 32'h5678) begin bad++;
      $display("FAIL mthi_mtlo: got %h %h want 00001234 00005678", hi, lo); end
    run_op(2'b10, 32'd99, 32'd0, c, rh, rl, dz, bz, pb);
    total++; if (c !== 1 || dz !== 1'b1) begin bad++;
      $display("FAIL divzero_flag: got cyc=%0d dz=%b want 1 1", c, dz); end
    total++; if (rh !== 32'h1234 || rl !== 32'h5678) begin bad++;
      $display("FAIL divzero_hilo: got %h %h want 00001234 00005678", rh, rl); end
    total++; if (div_zero !== 1'b0 || pb !== 1'b0) begin bad++;
      $display("FAIL divzero_pulse: got dz=%b busy=%b want 0 0", div_zero, pb); end
  endtask

  task automatic test_busy_ignore();
    int ndone = 0; int dcyc = -1; logic [31:0] rh = '0, rl = '0;
    op = 2'b00; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      start   = (c == 5);
      hi_load = (c == 10);
      op = (c == 5) ? 2'b11 : 2'b00;
      a  = (c == 5 || c == 10) ? 32'hDEAD_BEEF : 32'h0;
      b  = (c == 5) ? 32'd3 : 32'h0;
      if (done) begin ndone++; dcyc = c; rh = hi; rl = lo; end
      tick();
    end
    start = 1'b0; hi_load = 1'b0;
    total++; if (ndone !== 1 || dcyc !== 34) begin bad++;
      $display("FAIL busy_ignore_done: got count=%0d cyc=%0d want 1 34", ndone, dcyc); end
    total++; if (rh !== 32'hFFFF_FFFF || rl !== 32'hFFFF_FFEB) begin bad++;
      $display("FAIL busy_ignore_result: got %h_%h want ffffffff_ffffffeb", rh, rl); end
  endtask

  task automatic test_reset_abort();
    int c; int ndone = 0; logic [31:0] rh, rl; logic dz, bz, pb;
    op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 12; k++) begin
      if (done) ndone++;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || ndone !== 0) begin bad++;
      $display("FAIL reset_abort: got busy=%b done=%b hi=%h lo=%h early=%0d want 0 0 0 0 0",
               busy, done, hi, lo, ndone); end
    for (int k = 0; k < 40; k++) begin
      if (done) ndone++;
      tick();
    end
    total++; if (ndone !== 0) begin bad++;
      $display("FAIL reset_abort_nodone: got %0d done pulses want 0", ndone); end
    run_op(2'b11, 32'd100, 32'd9, c, rh, rl, dz, bz, pb);
    total++; if (c !== 34 || rl !== 32'd11 || rh !== 32'd1) begin bad++;
      $display("FAIL reset_fresh_divu: got cyc=%0d q=%h r=%h want 34 0000000b 00000001", c, rl, rh); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hi_load = 1'b0; lo_load = 1'b0;
    op = 2'b00; a = '0; b = '0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
